// File: rtl/gpio_link_ctrl.sv
// gpio_link_ctrl: 32-bit word transfers over the PULPino GPIO byte lane
// with 2-bit turn tokens, a TX ack timeout and RX back-pressure.
module gpio_link_ctrl #(
  parameter int pTIMEOUT_W  = 16,
  parameter int pWORD_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  abort,
  input  logic [31:0]           tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_done,
  output logic [31:0]           rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [pTIMEOUT_W-1:0] timeout_limit,
  output logic                  err_timeout,
  output logic [7:0]            gpio_data_in,
  output logic [1:0]            data_in_io_turn,
  input  logic [1:0]            data_in_pulpino_turn,
  input  logic [7:0]            gpio_data_out,
  input  logic [1:0]            data_out_pulpino_turn,
  output logic [1:0]            data_out_io_turn
);

  localparam int IW = 2;
  localparam logic [IW-1:0] LAST = IW'(pWORD_BYTES - 1);

  typedef enum logic [1:0] {
    TX_IDLE, TX_PUT, TX_WAIT, TX_DONE
  } tx_state_t;

  typedef enum logic {
    RX_COLLECT, RX_FULL
  } rx_state_t;

  tx_state_t             tx_state, tx_state_n;
  logic [IW-1:0]         tx_idx, tx_idx_n;
  logic [31:0]           tx_word, tx_word_n;
  logic [pTIMEOUT_W-1:0] timer, timer_n;
  logic                  err_n;
  logic [7:0]            tx_byte_n;
  logic [1:0]            tx_tok_n;
  logic                  tx_ack;

  rx_state_t             rx_state, rx_state_n;
  logic [IW-1:0]         rx_idx, rx_idx_n;
  logic [31:0]           rx_buf_n;
  logic [1:0]            rx_tok_n;

  assign tx_ready = (tx_state == TX_IDLE);
  assign tx_done  = (tx_state == TX_DONE);
  assign rx_valid = (rx_state == RX_FULL);
  assign tx_ack   = (data_in_pulpino_turn == data_in_io_turn);

  // Each byte lands on the lane when PUT is entered; the token moves a cycle later.
  always_comb begin
    tx_state_n = tx_state;
    tx_idx_n   = tx_idx;
    tx_word_n  = tx_word;
    timer_n    = timer;
    err_n      = err_timeout;
    tx_byte_n  = gpio_data_in;
    tx_tok_n   = data_in_io_turn;
    if (abort) begin
      tx_state_n = TX_IDLE;
      tx_idx_n   = '0;
      err_n      = 1'b0;
    end else begin
      unique case (tx_state)
        TX_IDLE: begin
          if (tx_valid) begin
            tx_word_n  = tx_data;
            tx_idx_n   = '0;
            tx_byte_n  = tx_data[7:0];
            tx_state_n = TX_PUT;
          end
        end
        TX_PUT: begin
          timer_n    = '0;
          tx_tok_n   = data_in_io_turn + 2'd1;
          tx_state_n = TX_WAIT;
        end
        TX_WAIT: begin
          timer_n = timer + pTIMEOUT_W'(1);
          if (tx_ack) begin
            if (tx_idx == LAST) begin
              tx_state_n = TX_DONE;
            end else begin
              tx_idx_n   = tx_idx + IW'(1);
              tx_byte_n  = tx_word[{tx_idx_n, 3'b000} +: 8];
              tx_state_n = TX_PUT;
            end
          end else if (timeout_limit != '0 && timer == timeout_limit) begin
            err_n      = 1'b1;
            tx_state_n = TX_IDLE;
          end
        end
        TX_DONE: tx_state_n = TX_IDLE;
        default: tx_state_n = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state        <= TX_IDLE;
      tx_idx          <= '0;
      tx_word         <= '0;
      timer           <= '0;
      err_timeout     <= 1'b0;
      gpio_data_in    <= '0;
      data_in_io_turn <= '0;
    end else begin
      tx_state        <= tx_state_n;
      tx_idx          <= tx_idx_n;
      tx_word         <= tx_word_n;
      timer           <= timer_n;
      err_timeout     <= err_n;
      gpio_data_in    <= tx_byte_n;
      data_in_io_turn <= tx_tok_n;
    end
  end

  // The ack mirrors PULPino's token, so skipped token values are tolerated.
  always_comb begin
    rx_state_n = rx_state;
    rx_idx_n   = rx_idx;
    rx_buf_n   = rx_data;
    rx_tok_n   = data_out_io_turn;
    if (abort) begin
      rx_state_n = RX_COLLECT;
      rx_idx_n   = '0;
    end else begin
      unique case (rx_state)
        RX_COLLECT: begin
          if (data_out_pulpino_turn != data_out_io_turn) begin
            rx_buf_n[{rx_idx, 3'b000} +: 8] = gpio_data_out;
            rx_tok_n = data_out_pulpino_turn;
            if (rx_idx == LAST) begin
              rx_idx_n   = '0;
              rx_state_n = RX_FULL;
            end else begin
              rx_idx_n = rx_idx + IW'(1);
            end
          end
        end
        RX_FULL: begin
          if (rx_ready) rx_state_n = RX_COLLECT;
        end
        default: rx_state_n = RX_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_state         <= RX_COLLECT;
      rx_idx           <= '0;
      rx_data          <= '0;
      data_out_io_turn <= '0;
    end else begin
      rx_state         <= rx_state_n;
      rx_idx           <= rx_idx_n;
      rx_data          <= rx_buf_n;
      data_out_io_turn <= rx_tok_n;
    end
  end

endmodule

// File: tb/tb_gpio_link_ctrl.sv
// tb_gpio_link_ctrl: directed vector table, corner sequences and random
// full-duplex traffic against a PULPino/host reference model.
module tb_gpio_link_ctrl;
  logic        clk = 1'b0;
  logic        resetn, abort, tx_valid, tx_ready, tx_done;
  logic        rx_valid, rx_ready, err_timeout;
  logic [31:0] tx_data, rx_data;
  logic [15:0] timeout_limit;
  logic [7:0]  gpio_data_in, gpio_data_out;
  logic [1:0]  data_in_io_turn, data_in_pulpino_turn;
  logic [1:0]  data_out_pulpino_turn, data_out_io_turn;

  logic [1:0]  pulp_tx_tok = 2'd0;
  int          tx_mode = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  tx_seen[$];
  logic [1:0]  mon_tok = 2'd0;
  logic [1:0]  mon_nxt;
  int          ack_wait = 0;
  int          ack_delay = 0;

  typedef struct {
    logic [31:0] tx_word;
    logic [31:0] tx_seq;
    logic [31:0] rx_seq;
    logic [31:0] rx_word;
  } vec_t;

  always #5 clk = ~clk;

  // PULPino TX ack: 0 = immediate mirror, 1 = never, 2 = random delay
  assign data_in_pulpino_turn = (tx_mode == 0) ? data_in_io_turn : pulp_tx_tok;

  gpio_link_ctrl dut (
    .clk                   (clk),
    .resetn                (resetn),
    .abort                 (abort),
    .tx_data               (tx_data),
    .tx_valid              (tx_valid),
    .tx_ready              (tx_ready),
    .tx_done               (tx_done),
    .rx_data               (rx_data),
    .rx_valid              (rx_valid),
    .rx_ready              (rx_ready),
    .timeout_limit         (timeout_limit),
    .err_timeout           (err_timeout),
    .gpio_data_in          (gpio_data_in),
    .data_in_io_turn       (data_in_io_turn),
    .data_in_pulpino_turn  (data_in_pulpino_turn),
    .gpio_data_out         (gpio_data_out),
    .data_out_pulpino_turn (data_out_pulpino_turn),
    .data_out_io_turn      (data_out_io_turn)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // PULPino side of the TX lane: latch the byte whenever the token moves
  always @(negedge clk) begin
    if (resetn && data_in_io_turn != mon_tok) begin
      mon_nxt = mon_tok + 2'd1;
      check("tx_token_step", data_in_io_turn, mon_nxt);
      tx_seen.push_back(gpio_data_in);
      mon_tok = data_in_io_turn;
    end
  end

  always @(negedge clk) begin
    if (tx_mode == 2 && pulp_tx_tok != data_in_io_turn) begin
      if (ack_wait >= ack_delay) begin
        pulp_tx_tok = data_in_io_turn;
        ack_wait    = 0;
        ack_delay   = $urandom_range(0, 20);
      end else begin
        ack_wait++;
      end
    end
  end

  task automatic send_tx(input logic [31:0] w, output int lat);
    int n = 0;
    while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
    check("tx_ready_wait", tx_ready, 1);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_busy", tx_ready, 0);
    lat = 1;
    while (!tx_done && lat < 3000) begin @(negedge clk); lat++; end
    if (!tx_done) lat = -1;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic [1:0] step = 2'd1);
    int n = 0;
    while (data_out_io_turn != data_out_pulpino_turn && n < 1000) begin
      @(negedge clk); n++;
    end
    check("rx_ack_wait_expired", n >= 1000, 0);
    gpio_data_out         = b;
    data_out_pulpino_turn = data_out_pulpino_turn + step;
  endtask

  task automatic wait_rx_valid(input string name);
    int n = 0;
    while (!rx_valid && n < 2000) begin @(negedge clk); n++; end
    check(name, rx_valid, 1);
  endtask

  task automatic consume_rx();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("rx_valid_drop", rx_valid, 0);
  endtask

  function automatic logic [31:0] seen_seq();
    logic [31:0] s = '0;
    for (int k = 0; k < tx_seen.size() && k < 4; k++) s = {s[23:0], tx_seen[k]};
    return s;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[4];
    int          lat, diffs, n;
    logic [63:0] snap;
    logic [1:0]  tok0, exp_tok, rtok;
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_rx[$];
    logic [31:0] got_rx[$];

    vecs[0] = '{32'hA1B2C3D4, 32'hD4C3B2A1, 32'h11223344, 32'h44332211};
    vecs[1] = '{32'h00000000, 32'h00000000, 32'hFF00FF00, 32'h00FF00FF};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80010203, 32'h03020180};
    vecs[3] = '{32'h5A0FC381, 32'h81C30F5A, 32'hDEADBEEF, 32'hEFBEADDE};

    resetn = 1'b0; abort = 1'b0; tx_valid = 1'b0; tx_data = '0;
    rx_ready = 1'b0; timeout_limit = '0; gpio_data_out = '0;
    data_out_pulpino_turn = '0;
    tick(3);
    resetn = 1'b1;
    tick(1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_done", tx_done, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_err", err_timeout, 0);
    check("rst_gpio", gpio_data_in, 0);
    check("rst_tx_tok", data_in_io_turn, 0);
    check("rst_rx_tok", data_out_io_turn, 0);
    check("rst_rx_data", rx_data, 0);

    snap  = {tx_ready, tx_done, rx_valid, err_timeout, gpio_data_in,
             data_in_io_turn, data_out_io_turn, rx_data};
    diffs = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if ({tx_ready, tx_done, rx_valid, err_timeout, gpio_data_in,
           data_in_io_turn, data_out_io_turn, rx_data} !== snap) diffs++;
    end
    check("idle_stable", diffs, 0);

    for (int i = 0; i < 4; i++) begin
      tx_seen.delete();
      send_tx(vecs[i].tx_word, lat);
      check("tx_latency", lat, 9);
      tick(1);
      check("tx_done_once", tx_done, 0);
      check("tx_nbytes", tx_seen.size(), 4);
      check("tx_bytes", seen_seq(), vecs[i].tx_seq);
      check("tx_token_wrap", data_in_io_turn, 0);
      for (int k = 0; k < 4; k++) rx_send(vecs[i].rx_seq[31-8*k -: 8]);
      wait_rx_valid("rx_valid_wait");
      check("rx_word", rx_data, vecs[i].rx_word);
      check("rx_token_mirror", data_out_io_turn, data_out_pulpino_turn);
      consume_rx();
    end

    // back-pressure: a 5th token stays unacked while the word is held
    rx_send(8'h11); rx_send(8'h22); rx_send(8'h33); rx_send(8'h44);
    wait_rx_valid("bp_valid");
    check("bp_word", rx_data, 32'h44332211);
    rtok = data_out_io_turn;
    rx_send(8'h55);
    tick(10);
    check("bp_no_ack", data_out_io_turn, rtok);
    check("bp_valid_held", rx_valid, 1);
    check("bp_data_held", rx_data, 32'h44332211);
    consume_rx();
    check("bp_no_ack_same_cycle", data_out_io_turn, rtok);
    tick(1);
    check("bp_acked", data_out_io_turn, data_out_pulpino_turn);
    rx_send(8'h66); rx_send(8'h77); rx_send(8'h88);
    wait_rx_valid("bp_valid2");
    check("bp_word2", rx_data, 32'h88776655);
    consume_rx();

    // timeout with PULPino never acking
    tx_mode = 1; pulp_tx_tok = data_in_io_turn; tok0 = data_in_io_turn;
    timeout_limit = 16'd10;
    tx_data = 32'hCAFEF00D; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(10);
    check("to_not_yet", err_timeout, 0);
    check("to_busy", tx_ready, 0);
    tick(2);
    check("to_err", err_timeout, 1);
    check("to_idle", tx_ready, 1);
    exp_tok = tok0 + 2'd1;
    check("to_token_kept", data_in_io_turn, exp_tok);
    tick(5);
    check("to_err_sticky", err_timeout, 1);

    // abort during TX byte 2 and RX byte 1
    tx_mode = 0;
    rx_send(8'hAA);
    n = 0;
    while (data_out_io_turn != data_out_pulpino_turn && n < 100) begin tick(1); n++; end
    rtok = data_out_io_turn;
    tok0 = data_in_io_turn;
    tx_data = 32'h0BADBEEF; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("ab_tx_ready", tx_ready, 1);
    check("ab_err_clr", err_timeout, 0);
    check("ab_rx_valid", rx_valid, 0);
    exp_tok = tok0 + 2'd3;
    check("ab_tx_token", data_in_io_turn, exp_tok);
    check("ab_tx_byte", gpio_data_in, 8'hAD);
    check("ab_rx_token", data_out_io_turn, rtok);
    tick(2);
    tx_seen.delete();
    send_tx(32'h13579BDF, lat);
    check("ab_tx_latency", lat, 9);
    tick(1);
    check("ab_tx_bytes", seen_seq(), 32'hDF9B5713);
    rx_send(8'h01, 2'd2); rx_send(8'h02); rx_send(8'h03); rx_send(8'h04);
    wait_rx_valid("ab_rx_valid_wait");
    check("ab_rx_word", rx_data, 32'h04030201);
    check("ab_rx_jump_mirror", data_out_io_turn, data_out_pulpino_turn);
    consume_rx();

    // timeout disabled: waits indefinitely, then completes once acked
    timeout_limit = '0; tx_mode = 1; pulp_tx_tok = data_in_io_turn;
    tx_seen.delete();
    tx_data = 32'h2468ACE0; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(300);
    check("nolimit_wait", tx_ready, 0);
    check("nolimit_no_err", err_timeout, 0);
    ack_wait = 0; ack_delay = 0; tx_mode = 2;
    n = 0;
    while (!tx_done && n < 3000) begin tick(1); n++; end
    check("nolimit_done", tx_done, 1);
    tick(1);
    check("nolimit_bytes", seen_seq(), 32'hE0AC6824);

    // random full duplex against the scoreboard
    pulp_tx_tok = data_in_io_turn;
    tx_seen.delete();
    fork
      begin : tx_proc
        int          l;
        logic [31:0] d;
        for (int w = 0; w < 16; w++) begin
          d = $urandom;
          for (int k = 0; k < 4; k++) exp_tx.push_back(8'((d >> (8 * k)) & 32'hFF));
          send_tx(d, l);
          check("rnd_tx_done", l > 0, 1);
          tick($urandom_range(0, 5));
        end
      end
      begin : rx_proc
        logic [31:0] word;
        logic [7:0]  b;
        for (int w = 0; w < 16; w++) begin
          word = '0;
          for (int k = 0; k < 4; k++) begin
            b    = 8'($urandom);
            word = word | (32'(b) << (8 * k));
            tick($urandom_range(0, 20));
            rx_send(b);
          end
          exp_rx.push_back(word);
        end
      end
      begin : host_proc
        int h = 0;
        while (got_rx.size() < 16 && h < 30000) begin
          @(negedge clk); h++;
          rx_ready = ($urandom_range(0, 1) == 1);
          if (rx_valid && rx_ready) got_rx.push_back(rx_data);
        end
      end
    join
    rx_ready = 1'b0;
    tick(2);

    check("rnd_tx_nbytes", tx_seen.size(), 64);
    diffs = 0;
    for (int i = 0; i < 64; i++)
      if (i >= tx_seen.size() || tx_seen[i] !== exp_tx[i]) diffs++;
    check("rnd_tx_bytes", diffs, 0);
    check("rnd_rx_nwords", got_rx.size(), 16);
    for (int i = 0; i < 16 && i < got_rx.size(); i++)
      check("rnd_rx_word", got_rx[i], exp_rx[i]);
    check("rnd_rx_idle", rx_valid, 0);
    check("rnd_rx_tok", data_out_io_turn, data_out_pulpino_turn);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
